// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Reader side of the instruction ROM port. Owns the program counter, drives
//   the ROM byte address and absorbs the ROM's one-cycle registered read
//   latency. Fetched words are buffered in a small FIFO and handed to decode
//   as {instruction, pc} over a valid/ready handshake. A branch redirects the
//   PC and throws away every wrong-path word, buffered or still in flight.
//
// Parameters:
//   RESET_PC   first fetch address after reset release
//   PC_STEP    byte increment per sequential fetch
//   BUF_DEPTH  output FIFO entries (2 or 4)
//
// Ports:
//   clk            in   1   single clock, rising edge
//   reset          in   1   asynchronous reset, active-low
//   rom_dir        out  32  ROM byte address, sampled by the ROM at posedge
//   rom_instr      in   32  ROM data, valid the cycle after rom_dir was sampled
//   branch_valid   in   1   redirect request, single-cycle pulse
//   branch_target  in   32  redirect byte address (bits [1:0] ignored)
//   inst_valid     out  1   inst_data/inst_pc hold a valid entry
//   inst_ready     in   1   decode accepts the head entry when valid && ready
//   inst_data      out  32  head instruction word
//   inst_pc        out  32  byte address of inst_data
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PC_STEP   = 4,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_dir,
  input  logic [31:0] rom_instr,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       state;
  logic [31:0]      pc;
  logic [31:0]      req_pc;
  logic             inflight;

  logic [31:0]      fifo_data [BUF_DEPTH];
  logic [31:0]      fifo_pc   [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             pop;
  logic             push;
  logic             issue;
  logic             room;
  logic [OCC_W-1:0] occ_next;
  logic [31:0]      branch_pc;

  // The ROM address is the PC register itself, so no input reaches rom_dir
  // combinationally and the address stays put while fetch is stalled.
  assign rom_dir    = pc;
  assign branch_pc  = branch_target & 32'hFFFF_FFFC;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;

  // Room must account for the word already on its way back from the ROM,
  // otherwise a stall could arrive with the FIFO full and one word pending.
  assign occ_next   = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign room       = occ_next < OCC_W'(BUF_DEPTH);
  assign issue      = (state == ST_RUN) && room && !branch_valid;

  // A word returning during the branch cycle belongs to the wrong path.
  assign push       = inflight && !branch_valid;

  // Empty FIFO presents zeros rather than stale entries.
  assign inst_data  = inst_valid ? fifo_data[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;

  // Fetch control: PC advance, in-flight tracking and the BOOT/RUN/FLUSH
  // sequencing. BOOT gives the ROM one idle cycle to leave its own reset;
  // FLUSH is the bubble while the redirected address settles on rom_dir.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      req_pc   <= 32'h0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc <= pc;
        pc     <= pc + 32'(PC_STEP);
      end
      if (branch_valid) begin
        pc    <= branch_pc;
        state <= ST_FLUSH;
      end else begin
        case (state)
          ST_BOOT:  state <= ST_RUN;
          ST_RUN:   state <= ST_RUN;
          ST_FLUSH: state <= ST_RUN;
          default:  state <= ST_BOOT;
        endcase
      end
    end
  end

  // FIFO bookkeeping. A branch empties it outright; a pop in the branch cycle
  // still completes because the consumer has already taken the head word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage has no reset; outputs are gated by inst_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rom_instr;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Purpose:
//   Self-checking bench for instr_fetch_unit. A behavioural ROM returns
//   32'h1000_0000 + (address >> 2) one cycle after the address is sampled.
//   The stimulus process queues the words decode is expected to accept; a
//   monitor process pops the queue on every handshake and compares.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } word_t;

  logic        clk;
  logic        reset;
  logic [31:0] rom_dir;
  logic [31:0] rom_instr;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  word_t       expQ[$];
  word_t       expWord;
  int          testsRun    = 0;
  int          testsFailed = 0;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .PC_STEP   (4),
    .BUF_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_dir       (rom_dir),
    .rom_instr     (rom_instr),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROM model with one cycle of latency.
  always @(posedge clk) begin
    rom_instr <= 32'h1000_0000 + (rom_dir >> 2);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Inputs change just after a rising edge; the task returns at the
  // following falling edge, where the new cycle's outputs are observed.
  task automatic applyStimulus(input logic rstN, input logic rdy,
                               input logic brv, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset         = rstN;
    inst_ready    = rdy;
    branch_valid  = brv;
    branch_target = tgt;
    @(negedge clk);
  endtask

  task automatic expectWord(input logic [31:0] pc, input logic [31:0] data);
    expQ.push_back('{pc: pc, data: data});
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
    checkOutput({tag, "_data"},  inst_data, 32'h0);
    checkOutput({tag, "_pc"},    inst_pc,   32'h0);
    checkOutput({tag, "_romdir"}, rom_dir,  32'h0);
  endtask

  // Release reset with decode ready and consume the first four words.
  task automatic bootRun(input string tag);
    expectWord(32'h0000_0000, 32'h1000_0000);
    expectWord(32'h0000_0004, 32'h1000_0001);
    expectWord(32'h0000_0008, 32'h1000_0002);
    expectWord(32'h0000_000C, 32'h1000_0003);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput({tag, "_valid_R"}, {31'b0, inst_valid}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput({tag, "_valid_R1"}, {31'b0, inst_valid}, 32'h0);
    checkOutput({tag, "_romdir_R1"}, rom_dir, 32'h0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput({tag, "_valid_R2"}, {31'b0, inst_valid}, 32'h0);
    checkOutput({tag, "_romdir_R2"}, rom_dir, 32'h0000_0004);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput({tag, "_valid_R3"}, {31'b0, inst_valid}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput({tag, "_stream_valid"}, {31'b0, inst_valid}, 32'h1);
    end
  endtask

  // Scoreboard monitor: every accepted word must be the next expected one.
  always @(negedge clk) begin
    if (reset && inst_valid && inst_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL sb_unexpected: got pc %h data %h, required no handshake",
                 inst_pc, inst_data);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("sb_pc",   inst_pc,   expWord.pc);
        checkOutput("sb_data", inst_data, expWord.data);
      end
    end
  end

  initial begin
    reset         = 1'b0;
    inst_ready    = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 32'h0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkResetOutputs("reset");

    // T1: linear fetch from reset
    bootRun("t1");

    // Reset while running
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkResetOutputs("midrun_reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // T2: stall from the first valid word, then resume
    expectWord(32'h0000_0000, 32'h1000_0000);
    expectWord(32'h0000_0004, 32'h1000_0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_valid",  {31'b0, inst_valid}, 32'h1);
      checkOutput("stall_pc",     inst_pc,   32'h0000_0000);
      checkOutput("stall_data",   inst_data, 32'h1000_0000);
      checkOutput("stall_romdir", rom_dir,   32'h0000_0008);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("resume_valid0", {31'b0, inst_valid}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("resume_pc1", inst_pc, 32'h0000_0004);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("prebranch_pc", inst_pc, 32'h0000_0008);

    // T3: branch to 0x40 with words 8 and 12 buffered
    expectWord(32'h0000_0040, 32'h1000_0010);
    expectWord(32'h0000_0044, 32'h1000_0011);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("t3_bubble_valid", {31'b0, inst_valid}, 32'h0);
      if (i == 1) checkOutput("t3_flush_romdir", rom_dir, 32'h0000_0040);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_valid_B4", {31'b0, inst_valid}, 32'h1);
    checkOutput("t3_pc_B4", inst_pc, 32'h0000_0040);

    // T4: branch to 0x100 in the same cycle word 0x44 is accepted
    expectWord(32'h0000_0100, 32'h1000_0040);
    expectWord(32'h0000_0104, 32'h1000_0041);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("t4_bubble_valid", {31'b0, inst_valid}, 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_pc_B4", inst_pc, 32'h0000_0100);

    // T5: unaligned target near the top of memory, PC wraps to zero
    expectWord(32'hFFFF_FFFC, 32'h4FFF_FFFF);
    expectWord(32'h0000_0000, 32'h1000_0000);
    expectWord(32'h0000_0004, 32'h1000_0001);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("t5_bubble_valid", {31'b0, inst_valid}, 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_pc_top", inst_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_pc_wrap", inst_pc, 32'h0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

    // T6: stall until the FIFO is full, then reset
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_hold_pc", inst_pc, 32'h0000_0008);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_hold_pc2", inst_pc, 32'h0000_0008);
    checkOutput("t6_hold_romdir", rom_dir, 32'h0000_0010);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkResetOutputs("t6_reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    bootRun("t6_restart");

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("sb_drained", 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
